// File: rtl/deserializer_stream.sv
// Narrow-beat to word deserializer: packs LANES-bit beats into DATA_WIDTH-bit words
// and presents each word through a one-entry valid/ready register with sticky overflow.
module deserializer_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_wen,
    input  logic [LANES-1:0]                           i_data,
    input  logic                                       i_flush,
    input  logic                                       i_ovf_clr,
    input  logic                                       i_ready,
    output logic [DATA_WIDTH-1:0]                      o_data,
    output logic                                       o_valid,
    output logic [$clog2(DATA_WIDTH/LANES+1)-1:0]      o_count,
    output logic                                       o_overflow
);

    localparam int BEATS   = DATA_WIDTH / LANES;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int COUNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (LANES < 1 || LANES > DATA_WIDTH || (DATA_WIDTH % LANES) != 0) begin : g_bad_params
            $error("deserializer_stream: DATA_WIDTH must be a positive multiple of LANES");
        end
    endgenerate

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic [DATA_WIDTH-1:0] word_ins;

    logic accept;
    logic complete;
    logic handshake;
    logic load;
    logic drop;

    // Flush beats any same-cycle write; a discarded beat can never complete a word.
    assign accept    = i_wen && !i_flush;
    assign complete  = accept && (cnt_q == LAST_BEAT);
    assign handshake = o_valid && i_ready;
    assign load      = complete && (!o_valid || i_ready);
    assign drop      = complete && o_valid && !i_ready;

    // Partial word with the current beat inserted; on completion this is the full word.
    generate
        if (MSB_FIRST) begin : g_msb
            if (LANES == DATA_WIDTH) begin : g_single
                assign word_ins = i_data;
            end else begin : g_shift
                assign word_ins = {word_q[DATA_WIDTH-LANES-1:0], i_data};
            end
        end else begin : g_lsb
            // NOTE: every variable assigned in always_comb gets a default first, otherwise
            // a path that skips the assignment infers a latch.
            always_comb begin
                word_ins = word_q;
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        word_ins[k*LANES +: LANES] = i_data;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (i_flush) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (accept) begin
            word_d = word_ins;
            cnt_d  = complete ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // Output register: a completion during a handshake refills it with no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (load) begin
            o_data  <= word_ins;
            o_valid <= 1'b1;
        end else if (handshake) begin
            o_valid <= 1'b0;
        end
    end

    // A new overflow takes priority over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

    assign o_count = COUNT_W'(cnt_q);

endmodule

// File: doc/deserializer_stream.md
Name: deserializer_stream

Overview:
Parametrised successor to the single-bit deserializer. It accepts LANES bits per write beat and assembles them into DATA_WIDTH-bit words, with selectable LSB-first or MSB-first packing. A completed word is presented through a one-entry output register using a valid/ready handshake, with sticky overflow detection. It sits between a serial/narrow PHY-side front end and a word-oriented consumer such as a FIFO or bus bridge.

Parameters:
DATA_WIDTH, 8, output word width; must be an integer multiple of LANES (elaboration-time error otherwise).
LANES, 1, bits accepted per write beat; 1 <= LANES <= DATA_WIDTH.
MSB_FIRST, 0, 0 = first beat lands in the least significant bits; 1 = first beat lands in the most significant bits.

Ports:
i_clk  input  1  clock; all logic is clocked on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_wen  input  1  write enable; a beat is accepted on every cycle where i_wen=1.
i_data  input  LANES  beat data.
i_flush  input  1  synchronous clear of the partial word in progress.
i_ovf_clr  input  1  synchronous clear of o_overflow.
i_ready  input  1  consumer ready.
o_data  output  DATA_WIDTH  assembled word; stable while o_valid=1 and i_ready=0.
o_valid  output  1  o_data holds an unconsumed word.
o_count  output  clog2(BEATS+1)  number of beats in the current partial word.
o_overflow  output  1  sticky flag; a completed word was dropped.

Behaviour:
- BEATS = DATA_WIDTH/LANES. The beat counter runs 0..BEATS-1 and uses max(1,clog2(BEATS)) bits.
- Reset is asynchronous on i_rst_n=0. It clears the counter, the partial word, o_data, o_valid and o_overflow to 0. Reset deasserting in the middle of a word discards that partial word.
- LSB packing (MSB_FIRST=0): beat k writes i_data into bits [k*LANES +: LANES].
- MSB packing (MSB_FIRST=1): the shift register is updated as word = {word[DATA_WIDTH-LANES-1:0], i_data}, so beat 0 ends up in the top LANES bits. When LANES=DATA_WIDTH, the word is simply i_data.
- Accepted beat when the counter is below BEATS-1: the beat is stored and the counter increments.
- Accepted beat when the counter equals BEATS-1 (completion): the counter wraps to 0, and the full word including this beat is a candidate for the output register in the same edge.
- Latency: o_valid=1 and o_data=word in the cycle after the final beat is accepted.
- A handshake completes on any cycle where o_valid=1 and i_ready=1. If no new completion occurs in that cycle, o_valid goes to 0 at the next edge.
- Completion while o_valid=0: the word is loaded and o_valid is set to 1.
- Completion in the same cycle as a handshake: the new word is loaded and o_valid stays 1, giving back-to-back throughput of one word per BEATS cycles with no bubble.
- Completion while o_valid=1 and i_ready=0: the new word is dropped, o_data and o_valid are unchanged, o_overflow is set to 1, and the counter still wraps to 0.
- o_overflow stays set until i_ovf_clr=1 or reset. If i_ovf_clr and a new overflow occur in the same cycle, the flag is set (set wins).
- i_flush=1 zeroes the counter and the partial word. A beat presented in the same cycle is discarded (flush wins over i_wen). The output register, o_valid and o_overflow are not affected by flush.
- i_data is ignored while i_wen=0. The partial word bits above the current beat position hold unspecified values and are never visible on o_data.
- o_count equals the counter value; it reads 0 immediately after completion, flush or reset.

Test Plan:
- DATA_WIDTH=8, LANES=1, MSB_FIRST=0, i_ready=1; beats 1,0,1,1,0,0,1,0 -> o_data=0x4D with o_valid=1 for exactly one cycle, starting the cycle after the 8th beat.
- Same beats with MSB_FIRST=1 -> o_data=0xB2.
- LANES=2, DATA_WIDTH=8, MSB_FIRST=0; beats 01,10,11,00 -> o_data=0x39. Assert o_count steps 0,1,2,3,0 across the beats.
- i_ready=0; stream word 0xA5, then word 0x3C -> o_data holds 0xA5, o_overflow=1 after the second completion. Then i_ready=1 -> o_valid=0 on the next cycle. Then i_ovf_clr=1 -> o_overflow=0.
- Continuous i_wen with i_ready=1 for three words 0x11, 0x22, 0x33 -> o_valid pulses every 8 cycles, no word lost, o_overflow=0. Repeat with i_ready held 1 while the next word completes in the handshake cycle -> o_valid stays 1 across the change.
- Assert i_flush after 3 beats, then feed 8 beats of 0xF0 -> o_data=0xF0. Pulse i_rst_n low for half a cycle mid-word -> all outputs 0 immediately, and the next 8 beats form a clean word.
